// File: rtl/bram_rd_port.sv
// Read-side controller for a byte-write simple dual-port BRAM.
// It forwards writes from the issue cycle into the read data and returns responses in issue order through a 2-entry skid FIFO.
module bram_rd_port #(
    parameter int LEN_DATA  = 32,
    parameter int LEN_ADDR  = 8,
    parameter int byteWidth = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [LEN_ADDR-1:0]           req_addr,
    output logic                          bram_en,
    output logic [LEN_ADDR-1:0]           bram_addr,
    input  logic [LEN_DATA-1:0]           bram_dout,
    input  logic                          wr_en,
    input  logic [LEN_DATA/byteWidth-1:0] wr_we,
    input  logic [LEN_ADDR-1:0]           wr_addr,
    input  logic [LEN_DATA-1:0]           wr_din,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [LEN_DATA-1:0]           rsp_data,
    output logic [LEN_ADDR-1:0]           rsp_addr
);

    localparam int BYTES = LEN_DATA / byteWidth;

    logic                rst_hold;
    logic                inflight;
    logic [LEN_ADDR-1:0] inflight_addr;
    logic [BYTES-1:0]    fwd_mask;
    logic [LEN_DATA-1:0] fwd_data;
    logic [LEN_DATA-1:0] merged;

    logic [LEN_DATA-1:0] fifo_data [2];
    logic [LEN_ADDR-1:0] fifo_addr [2];
    logic                wptr;
    logic                rptr;
    logic [1:0]          count;

    logic                fire;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic [2:0]          pending;

    // Only registered terms feed the request handshake, so rsp_ready has no combinational path to req_ready.
    assign pending    = {1'b0, count} + {2'b00, inflight};
    assign req_ready  = !rst_hold && !flush && (pending < 3'd2);
    assign fire       = req_valid && req_ready;
    assign bram_en    = fire;
    assign bram_addr  = req_addr;
    assign fifo_empty = (count == 2'd0);

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        merged = bram_dout;
        for (int i = 0; i < BYTES; i++) begin
            if (fwd_mask[i]) begin
                merged[i*byteWidth +: byteWidth] = fwd_data[i*byteWidth +: byteWidth];
            end
        end
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_addr  = '0;
        if (!fifo_empty) begin
            rsp_valid = !flush;
            rsp_data  = fifo_data[rptr];
            rsp_addr  = fifo_addr[rptr];
        end else if (inflight) begin
            rsp_valid = !flush;
            rsp_data  = merged;
            rsp_addr  = inflight_addr;
        end
    end

    // The in-flight entry is queued whenever it cannot leave through the bypass path this cycle.
    assign pop  = !fifo_empty && rsp_ready && !flush;
    assign push = inflight && !flush && (!fifo_empty || !rsp_ready);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_hold      <= 1'b1;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            fwd_mask      <= '0;
            fwd_data      <= '0;
            wptr          <= 1'b0;
            rptr          <= 1'b0;
            count         <= 2'd0;
        end else begin
            rst_hold <= 1'b0;
            if (flush) begin
                inflight <= 1'b0;
                fwd_mask <= '0;
                wptr     <= 1'b0;
                rptr     <= 1'b0;
                count    <= 2'd0;
            end else begin
                inflight <= fire;
                if (fire) begin
                    inflight_addr <= req_addr;
                    fwd_data      <= wr_din;
                end
                // The BRAM is read-first, so a write at the issue edge is missing from bram_dout.
                fwd_mask <= (fire && wr_en && (wr_addr == req_addr)) ? wr_we : '0;
                if (push) wptr <= ~wptr;
                if (pop)  rptr <= ~rptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // NOTE: FIFO storage is not reset; count decides which entries are valid, and the data is written before it is read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wptr] <= merged;
            fifo_addr[wptr] <= inflight_addr;
        end
    end

endmodule
